kyber_poly_pingpong_buf: RTL and testbench

// Double-buffered (ping-pong) polynomial stream buffer placed between (I)NTT cores and their producers/consumers.

---
 rtl/kyber_poly_pingpong_buf_if.sv | 33 +++
 rtl/kyber_poly_pingpong_buf.sv | 172 +++++++++++++++++
 tb/tb_kyber_poly_pingpong_buf.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kyber_poly_pingpong_buf_if.sv
// Stream bundle for kyber_poly_pingpong_buf.
// Input stream: in_valid/in_ready/in_data with mode_in (word order, sampled
// with word 0) and a synchronous clear. Output stream: out_valid/out_ready/
// out_data with out_last, plus the done pulse and the bank occupancy level.
// slave = the buffer's view, master = the producer/consumer's view.
interface kyber_poly_pingpong_buf_if #(
  parameter int LANES   = 8,
  parameter int COEFF_W = 16
);
  localparam int W = LANES * COEFF_W;

  logic         clear;
  logic         mode_in;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         out_last;
  logic         done;
  logic [1:0]   level;

  modport slave (
    input  clear, mode_in, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, done, level
  );

  modport master (
    output clear, mode_in, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, done, level
  );
endinterface

// File: rtl/kyber_poly_pingpong_buf.sv
// kyber_poly_pingpong_buf: two-bank polynomial buffer. One bank fills from
// the input stream while the other drains to the registered output, in
// natural or bit-reversed word order, with an optional per-lane final
// conditional subtraction of Q.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (flags/counters only)
//   bus      kyber_poly_pingpong_buf_if.slave stream bundle

// Per-lane final reduction: one conditional subtraction of Q.
module kyber_ppb_lane_red #(
  parameter int COEFF_W = 16,
  parameter int Q       = 3329,
  parameter int REDUCE  = 1
) (
  input  logic [COEFF_W-1:0] c_i,
  output logic [COEFF_W-1:0] r_o
);
  if (REDUCE != 0) begin : g_red
    localparam logic [COEFF_W-1:0] QV = COEFF_W'(Q);
    assign r_o = (c_i >= QV) ? c_i - QV : c_i;
  end else begin : g_pass
    assign r_o = c_i;
  end
endmodule

module kyber_poly_pingpong_buf #(
  parameter int LANES   = 8,
  parameter int COEFF_W = 16,
  parameter int DEPTH   = 32,
  parameter int Q       = 3329,
  parameter int REDUCE  = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  kyber_poly_pingpong_buf_if.slave  bus
);
  localparam int W  = LANES * COEFF_W;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    for (int i = 0; i < AW; i++) bitrev[i] = a[AW-1-i];
  endfunction

  // storage: no reset, contents are don't-care until a bank is marked full
  logic [W-1:0] mem_q [2][DEPTH];

  logic [1:0]         full_q, full_d;
  logic [1:0]         mode_q, mode_d;
  logic               wbank_q, wbank_d;
  logic               rbank_q, rbank_d;
  logic [AW-1:0]      wcnt_q, wcnt_d;
  logic [AW-1:0]      rcnt_q, rcnt_d;
  logic               rdy_en_q;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [W-1:0]       out_data_q, out_data_d;
  logic               done_q, done_d;
  logic [1:0]         level_q, level_d;

  logic               wr_acc, rd_ld;
  logic [AW-1:0]      raddr;
  logic [LANES-1:0][COEFF_W-1:0] rd_lanes, red_lanes;

  // rdy_en_q holds in_ready low until the first edge after reset release
  assign bus.in_ready  = rdy_en_q && !full_q[wbank_q];
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.done      = done_q;
  assign bus.level     = level_q;

  assign wr_acc = bus.in_valid && bus.in_ready;
  assign rd_ld  = (!out_valid_q || bus.out_ready) && full_q[rbank_q];
  assign raddr  = mode_q[rbank_q] ? bitrev(rcnt_q) : rcnt_q;
  assign rd_lanes = mem_q[rbank_q][raddr];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    kyber_ppb_lane_red #(.COEFF_W(COEFF_W), .Q(Q), .REDUCE(REDUCE)) u_red (
      .c_i (rd_lanes[g]),
      .r_o (red_lanes[g])
    );
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !bus.clear) mem_q[wbank_q][wcnt_q] <= bus.in_data;
  end

  // Write and read sides touch different banks whenever both act: a write
  // needs !full[wbank], a read needs full[rbank].
  always_comb begin
    full_d      = full_q;
    mode_d      = mode_q;
    wbank_d     = wbank_q;
    rbank_d     = rbank_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    level_d     = level_q;
    if (bus.clear) begin
      full_d      = '0;
      wbank_d     = 1'b0;
      rbank_d     = 1'b0;
      wcnt_d      = '0;
      rcnt_d      = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      level_d     = '0;
    end else begin
      if (wr_acc) begin
        if (wcnt_q == '0) mode_d[wbank_q] = bus.mode_in;
        if (wcnt_q == LAST) begin
          full_d[wbank_q] = 1'b1;
          wcnt_d          = '0;
          wbank_d         = ~wbank_q;
        end else begin
          wcnt_d = wcnt_q + AW'(1);
        end
      end
      if (rd_ld) begin
        out_valid_d = 1'b1;
        out_data_d  = red_lanes;
        out_last_d  = (rcnt_q == LAST);
        if (rcnt_q == LAST) begin
          full_d[rbank_q] = 1'b0;
          rcnt_d          = '0;
          rbank_d         = ~rbank_q;
        end else begin
          rcnt_d = rcnt_q + AW'(1);
        end
      end else if (bus.out_ready) begin
        out_valid_d = 1'b0;
      end
      done_d  = out_valid_q && bus.out_ready && out_last_q;
      level_d = 2'(full_d[0]) + 2'(full_d[1]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q      <= '0;
      mode_q      <= '0;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      rdy_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      level_q     <= '0;
    end else begin
      full_q      <= full_d;
      mode_q      <= mode_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      rdy_en_q    <= 1'b1;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      level_q     <= level_d;
    end
  end
endmodule

// File: tb/tb_kyber_poly_pingpong_buf.sv
module tb_kyber_poly_pingpong_buf;
  localparam int LANES = 8, CW = 16, DEPTH = 32, Q = 3329, AW = 5;
  localparam int W = LANES * CW;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  kyber_poly_pingpong_buf_if #(.LANES(LANES), .COEFF_W(CW)) bus ();
  kyber_poly_pingpong_buf_if #(.LANES(LANES), .COEFF_W(CW)) bus2 ();

  kyber_poly_pingpong_buf #(.LANES(LANES), .COEFF_W(CW), .DEPTH(DEPTH), .Q(Q), .REDUCE(1))
    dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  // unreduced twin fed the same inputs
  kyber_poly_pingpong_buf #(.LANES(LANES), .COEFF_W(CW), .DEPTH(DEPTH), .Q(Q), .REDUCE(0))
    dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));
  assign bus2.clear     = bus.clear;
  assign bus2.mode_in   = bus.mode_in;
  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_data   = bus.in_data;
  assign bus2.out_ready = bus.out_ready;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [W-1:0] d; logic [W-1:0] raw; logic last; } exp_t;
  exp_t         q[$];
  logic [W-1:0] wbuf [DEPTH];
  int           wr_n = 0;
  logic         wmode = 1'b0;
  logic         exp_done = 1'b0;
  logic         hold_v = 1'b0;
  logic [W-1:0] hold_d = '0;
  int           done_cnt = 0, hs_cnt = 0, acc_cnt = 0;
  logic [W-1:0] cap[$], cap2[$];

  function automatic int brev(input int x);
    int r = 0;
    for (int b = 0; b < AW; b++) if (x & (1 << b)) r |= 1 << (AW - 1 - b);
    return r;
  endfunction

  function automatic logic [W-1:0] reduce_w(input logic [W-1:0] w);
    logic [W-1:0] r;
    int c;
    for (int k = 0; k < LANES; k++) begin
      c = int'(w[k*CW +: CW]);
      r[k*CW +: CW] = CW'((c >= Q) ? c - Q : c);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int a;
    if (!reset_n || bus.clear) begin
      q.delete();
      wr_n = 0;
      exp_done = 1'b0;
      hold_v = 1'b0;
    end else begin
      chk("done", bus.done, exp_done);
      if (bus.done) done_cnt++;
      if (hold_v) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data", bus.out_data, hold_d);
      end
      exp_done = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        hs_cnt++;
        cap.push_back(bus.out_data);
        cap2.push_back(bus2.out_data);
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out: got %h want none", bus.out_data);
        end else begin
          e = q.pop_front();
          chk("out_data", bus.out_data, e.d);
          chk("out_raw", bus2.out_data, e.raw);
          chk("out_last", bus.out_last, e.last);
          exp_done = e.last;
        end
      end
      hold_v = bus.out_valid && !bus.out_ready;
      hold_d = bus.out_data;
      if (bus.in_valid && bus.in_ready) begin
        acc_cnt++;
        if (wr_n == 0) wmode = bus.mode_in;
        wbuf[wr_n] = bus.in_data;
        wr_n++;
        if (wr_n == DEPTH) begin
          for (int i = 0; i < DEPTH; i++) begin
            a = wmode ? brev(i) : i;
            e.d = reduce_w(wbuf[a]);
            e.raw = wbuf[a];
            e.last = (i == DEPTH - 1);
            q.push_back(e);
          end
          wr_n = 0;
        end
      end
    end
  end

  // ---------------- consumer ----------------
  int rdy_mode = 1; // 0 hold low, 1 hold high, 2 random
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = ($urandom_range(0, 99) < 60);
      endcase
    end
  end

  // ---------------- drivers ----------------
  typedef struct { logic [CW-1:0] din; logic [CW-1:0] dout; } vec_t;
  vec_t tbl [8];

  task automatic put(input logic [W-1:0] d, input logic m, input int gap);
    int n;
    bit ok;
    n = (gap > 0) ? int'($urandom_range(0, gap)) : 0;
    repeat (n) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1; bus.in_data = d; bus.mode_in = m;
    n = 0;
    forever begin
      @(negedge clk); ok = bus.in_ready;
      @(posedge clk); #1;
      if (ok) break;
      if (++n > 2000) begin
        total++; bad++;
        $display("FAIL put_timeout: got in_ready=0 want 1");
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  // kind 0: every lane = word index; 1: table vectors; 2: random
  task automatic send_poly(input int kind, input logic m, input int gap);
    logic [W-1:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < LANES; k++)
        case (kind)
          0:       w[k*CW +: CW] = CW'(i);
          1:       w[k*CW +: CW] = tbl[(i + k) % 8].din;
          default: w[k*CW +: CW] = ($urandom_range(0, 3) == 0) ? CW'($urandom) : CW'($urandom_range(0, 2*Q-1));
        endcase
      put(w, m, gap);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || bus.out_valid) && n < 4000) begin
      @(posedge clk); #2; n++;
    end
    if (n >= 4000) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got running want finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int base, dc, a0, hs0, gaps, n;
    logic [W-1:0] w, w2;

    tbl[0] = '{16'd3328,  16'd3328};
    tbl[1] = '{16'd3329,  16'd0};
    tbl[2] = '{16'd3330,  16'd1};
    tbl[3] = '{16'd6657,  16'd3328};
    tbl[4] = '{16'd0,     16'd0};
    tbl[5] = '{16'd6658,  16'd3329};
    tbl[6] = '{16'd65535, 16'd62206};
    tbl[7] = '{16'd3000,  16'd3000};

    reset_n = 1'b0;
    bus.clear = 1'b0; bus.mode_in = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_level", bus.level, 0);
    @(negedge clk); reset_n = 1'b1; #1;
    chk("in_ready_pre_edge", bus.in_ready, 0);
    @(posedge clk); #1;
    chk("in_ready_post_edge", bus.in_ready, 1);

    // natural order
    base = cap.size(); dc = done_cnt;
    send_poly(0, 1'b0, 0);
    wait_drain();
    chk("t1_count", cap.size() - base, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      w = cap[base + i];
      for (int k = 0; k < LANES; k++) chk("t1_lane", w[k*CW +: CW], i);
    end
    chk("t1_done", done_cnt - dc, 1);
    chk("t1_level", bus.level, 0);

    // bit-reversed order
    base = cap.size(); dc = done_cnt;
    send_poly(0, 1'b1, 0);
    wait_drain();
    chk("t2_count", cap.size() - base, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      w = cap[base + i];
      chk("t2_lane0", w[0 +: CW], brev(i));
    end
    chk("t2_done", done_cnt - dc, 1);

    // reduction table, reduced and pass-through
    base = cap.size();
    send_poly(1, 1'b0, 0);
    wait_drain();
    for (int i = 0; i < DEPTH; i++) begin
      w = cap[base + i]; w2 = cap2[base + i];
      for (int k = 0; k < LANES; k++) begin
        chk("t3_reduced", w[k*CW +: CW], tbl[(i + k) % 8].dout);
        chk("t3_raw", w2[k*CW +: CW], tbl[(i + k) % 8].din);
      end
    end

    // back-to-back with consumer stalled
    rdy_mode = 0;
    repeat (2) begin @(posedge clk); #2; end
    a0 = acc_cnt; dc = done_cnt;
    fork
      for (int p = 0; p < 3; p++) send_poly(2, 1'(p), 0);
    join_none
    repeat (100) @(posedge clk);
    #2;
    chk("t4_accepts", acc_cnt - a0, 64);
    chk("t4_in_ready", bus.in_ready, 0);
    chk("t4_level", bus.level, 2);
    rdy_mode = 1;
    @(posedge clk); #2;
    gaps = 0;
    repeat (96) begin
      @(negedge clk);
      if (!bus.out_valid) gaps++;
    end
    chk("t4_gaps", gaps, 0);
    wait_drain();
    chk("t4_done", done_cnt - dc, 3);
    chk("t4_level_end", bus.level, 0);

    // random throttling, alternating mode
    rdy_mode = 2;
    base = cap.size();
    for (int p = 0; p < 4; p++) send_poly(2, 1'(p % 2), 3);
    wait_drain();
    chk("t5_count", cap.size() - base, 4 * DEPTH);

    // clear discards a partial polynomial
    rdy_mode = 1;
    for (int i = 0; i < 10; i++) put(W'($urandom), 1'b0, 0);
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    hs0 = hs_cnt;
    repeat (40) @(posedge clk);
    #2;
    chk("t6_no_out", hs_cnt - hs0, 0);
    chk("t6_level", bus.level, 0);
    chk("t6_in_ready", bus.in_ready, 1);

    // reset mid-drain
    send_poly(2, 1'b1, 0);
    n = 0;
    while (hs_cnt - hs0 < 5 && n < 500) begin @(posedge clk); #1; n++; end
    chk("t6_started", (hs_cnt - hs0 >= 5), 1);
    @(posedge clk); #3;
    reset_n = 1'b0; #1;
    chk("t6_rst_in_ready", bus.in_ready, 0);
    chk("t6_rst_out_valid", bus.out_valid, 0);
    chk("t6_rst_out_data", bus.out_data, 0);
    chk("t6_rst_out_last", bus.out_last, 0);
    chk("t6_rst_done", bus.done, 0);
    chk("t6_rst_level", bus.level, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1; #1;
    chk("t6_in_ready_pre", bus.in_ready, 0);
    @(posedge clk); #1;
    chk("t6_in_ready_post", bus.in_ready, 1);
    chk("t6_out_valid_post", bus.out_valid, 0);

    // recovery after reset
    base = cap.size(); dc = done_cnt;
    send_poly(0, 1'b0, 0);
    wait_drain();
    chk("t6_recover_count", cap.size() - base, DEPTH);
    chk("t6_recover_done", done_cnt - dc, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
